// File: rtl/aes_out_fifo_sequencer_pkg.sv
// Shared state encodings and sizing helpers for the AES output FIFO sequencer.
// The bench imports the same encodings.
package aes_out_fifo_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2,
    ST_DRAIN   = 2'd3
  } seq_state_e;

  // A rotation pointer needs at least one bit, even for a single core.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_out_fifo_sequencer.sv
// Gathers results from NUM_CORES AES cores in strict rotation and writes them to the
// output FIFO in block order, then hands the batch to the AXI-Stream master.
module aes_out_fifo_sequencer
  import aes_out_fifo_sequencer_pkg::*;
#(
  parameter int NUM_CORES       = 2,
  parameter int FIFO_SIZE       = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int FIFO_DATA_WIDTH = 128
) (
  input  logic                                 m00_axis_aclk,
  input  logic                                 m00_axis_areset,
  input  logic                                 batch_start,
  input  logic [FIFO_ADDR_WIDTH-1:0]           batch_blk_no,
  input  logic [NUM_CORES-1:0]                 core_req,
  input  logic [NUM_CORES*FIFO_DATA_WIDTH-1:0] core_data,
  output logic [NUM_CORES-1:0]                 core_grant,
  output logic                                 aes_controller_out_fifo_w_e,
  output logic [FIFO_ADDR_WIDTH-1:0]           aes_controller_out_fifo_addr,
  output logic [FIFO_DATA_WIDTH-1:0]           aes_controller_out_fifo_data,
  output logic [FIFO_ADDR_WIDTH-1:0]           aes_controller_out_fifo_blk_no,
  output logic                                 processing_done,
  input  logic                                 axis_out_fifo_tx_done,
  output logic                                 busy
);

  localparam int                         PTR_W    = ptr_width(NUM_CORES);
  localparam logic [PTR_W-1:0]           PTR_LAST = PTR_W'(NUM_CORES - 1);
  localparam logic [PTR_W-1:0]           PTR_ONE  = PTR_W'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] CNT_ONE  = FIFO_ADDR_WIDTH'(1);

  seq_state_e                  state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [FIFO_ADDR_WIDTH-1:0]  blk_no_q, blk_no_d;
  logic                        w_e_q, w_e_d;
  logic [FIFO_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [FIFO_DATA_WIDTH-1:0]  data_q, data_d;
  logic                        done_q, done_d;

  logic                        in_collect;
  logic                        grant_any;
  logic                        batch_ok;
  logic                        final_grant;
  logic [FIFO_DATA_WIDTH-1:0]  core_slice;

  assign in_collect  = (state_q == ST_COLLECT);
  assign batch_ok    = batch_start && (batch_blk_no != '0) && (int'(batch_blk_no) < FIFO_SIZE);
  assign final_grant = (wr_cnt_q == (blk_no_q - CNT_ONE));
  assign core_slice  = core_data[FIFO_DATA_WIDTH*int'(ptr_q) +: FIFO_DATA_WIDTH];

  // Only the core whose turn it is can be granted; others wait even when requesting.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_grant
    assign core_grant[gi] = in_collect && core_req[gi] && (ptr_q == PTR_W'(gi));
  end

  assign grant_any = |core_grant;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_cnt_d = wr_cnt_q;
    blk_no_d = blk_no_q;
    w_e_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (batch_ok) begin
          blk_no_d = batch_blk_no;
          wr_cnt_d = '0;
          ptr_d    = '0;
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (grant_any) begin
          w_e_d  = 1'b1;
          addr_d = wr_cnt_q;
          data_d = core_slice;
          ptr_d  = (ptr_q == PTR_LAST) ? '0 : (ptr_q + PTR_ONE);
          // The count stops at blk_no-1 so it never runs past the batch.
          if (final_grant) begin
            state_d = ST_DONE;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (axis_out_fifo_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      wr_cnt_q <= '0;
      blk_no_q <= '0;
      w_e_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_cnt_q <= wr_cnt_d;
      blk_no_q <= blk_no_d;
      w_e_q    <= w_e_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  // processing_done trails the final write by a cycle so a two-cycle SRAM read sees it.
  assign processing_done                = done_q;
  assign aes_controller_out_fifo_w_e    = w_e_q;
  assign aes_controller_out_fifo_addr   = addr_q;
  assign aes_controller_out_fifo_data   = data_q;
  assign aes_controller_out_fifo_blk_no = blk_no_q;
  assign busy                           = (state_q != ST_IDLE);

endmodule
